// File: rtl/gate_tt_checker_if.sv
// Bus between the truth-table checker and the gate under test / controlling environment.
// The master side is the checker; the slave side drives start and returns the gate output.
interface gate_tt_checker_if;
   logic       start;
   logic       gate_y;
   logic       a;
   logic       b;
   logic [1:0] vec_idx;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] err_mask;

   modport master (
      input  start, gate_y,
      output a, b, vec_idx, busy, done, pass, err_count, err_mask
   );

   modport slave (
      output start, gate_y,
      input  a, b, vec_idx, busy, done, pass, err_count, err_mask
   );
endinterface

// File: rtl/gate_tt_checker.sv
// Sweeps a two-input gate through {a,b} = 00..11, samples its output after a settle time
// and scores each sample against EXP_TT (bit k is the expected output for {a,b} == k).
module gate_tt_checker #(
   parameter logic [3:0] EXP_TT      = 4'b0001,
   parameter int         HOLD_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   gate_tt_checker_if.master  bus
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_hold_range
      $error("HOLD_CYCLES must lie in 1..15");
   end

   localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t     state_q;
   logic [3:0] cnt_q;
   logic       a_q;
   logic       b_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [2:0] err_count_q;
   logic [3:0] err_mask_q;

   logic       mismatch;
   logic [2:0] err_count_d;
   logic [3:0] err_mask_d;

   // {a,b} doubles as the vector index, so the expectation lookup needs no extra register.
   always_comb begin
      mismatch    = (bus.gate_y != EXP_TT[{a_q, b_q}]);
      err_count_d = err_count_q + {2'b00, mismatch};
      err_mask_d  = err_mask_q | ({3'b000, mismatch} << {a_q, b_q});
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= '0;
         err_mask_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  a_q         <= 1'b0;
                  b_q         <= 1'b0;
                  err_count_q <= '0;
                  err_mask_q  <= '0;
                  pass_q      <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= S_APPLY;
               end
            end
            S_APPLY: begin
               cnt_q   <= HOLD_INIT;
               state_q <= S_SETTLE;
            end
            S_SETTLE: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= S_CHECK;
            end
            S_CHECK: begin
               err_count_q <= err_count_d;
               err_mask_q  <= err_mask_d;
               if ({a_q, b_q} == 2'd3) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_count_d == 3'd0);
                  state_q <= S_DONE;
               end else begin
                  {a_q, b_q} <= {a_q, b_q} + 2'd1;
                  state_q    <= S_APPLY;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.vec_idx   = {a_q, b_q};
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_count_q;
   assign bus.err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: two instances (HOLD_CYCLES 1 and 3), each driving a
// table-modelled gate; expected sweep results are queued at start and checked on done.
module tb_gate_tt_checker;

   localparam logic [3:0] TT_NOR      = 4'b0001;
   localparam logic [3:0] TT_OR       = 4'b1110;
   localparam logic [3:0] TT_NOR_S11  = 4'b1001;

   typedef struct {
      int         inst;
      logic [3:0] mask;
      logic [2:0] cnt;
      logic       pass;
      int         done_cyc;
      int         busy_cycles;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [3:0] tt1;
   logic [3:0] tt3;

   exp_t sb[$];
   int   run_len [2];
   int   busy_cnt[2];
   int   prev_vec[2];

   gate_tt_checker_if if1 ();
   gate_tt_checker_if if3 ();

   assign if1.gate_y = tt1[{if1.a, if1.b}];
   assign if3.gate_y = tt3[{if3.a, if3.b}];

   gate_tt_checker u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   gate_tt_checker #(.EXP_TT(4'b0001), .HOLD_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int hold_of(input int inst);
      return (inst == 0) ? 1 : 3;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   task automatic mon_one(input int i, input logic busy, input logic done, input logic a,
                          input logic b, input logic [1:0] vec, input logic pass,
                          input logic [2:0] cnt, input logic [3:0] mask);
      exp_t e;
      int   h;
      h = hold_of(i);
      if (!busy && !done) begin
         busy_cnt[i] = 0;
         run_len[i]  = 0;
      end
      if (busy) begin
         check($sformatf("ab_eq_vec%0d", i), int'({a, b}), int'(vec));
         if (busy_cnt[i] != 0 && int'(vec) != prev_vec[i]) begin
            check($sformatf("vec_hold%0d", i), run_len[i], h + 2);
            check($sformatf("vec_step%0d", i), int'(vec), prev_vec[i] + 1);
            run_len[i] = 1;
         end else begin
            run_len[i]++;
         end
         prev_vec[i] = int'(vec);
         busy_cnt[i]++;
      end
      if (done) begin
         if (sb.size() == 0) begin
            fail_now($sformatf("spurious_done%0d", i));
         end else begin
            e = sb.pop_front();
            check("done_inst",   i,               e.inst);
            check("err_mask",    int'(mask),      int'(e.mask));
            check("err_count",   int'(cnt),       int'(e.cnt));
            check("pass",        int'(pass),      int'(e.pass));
            check("done_cycle",  cyc,             e.done_cyc);
            check("busy_cycles", busy_cnt[i],     e.busy_cycles);
            check("last_hold",   run_len[i],      h + 2);
            check("busy_in_done", int'(busy),     0);
         end
         busy_cnt[i] = 0;
         run_len[i]  = 0;
      end
   endtask

   always @(negedge clk) begin
      mon_one(0, if1.busy, if1.done, if1.a, if1.b, if1.vec_idx, if1.pass, if1.err_count, if1.err_mask);
      mon_one(1, if3.busy, if3.done, if3.a, if3.b, if3.vec_idx, if3.pass, if3.err_count, if3.err_mask);
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) if1.start = v;
      else           if3.start = v;
   endtask

   task automatic start_pulse(input int inst);
      set_start(inst, 1'b1);
      @(negedge clk);
      set_start(inst, 1'b0);
   endtask

   // Queues the expected result and returns E0, the edge that samples start.
   task automatic issue(input int inst, input logic [3:0] tt, input logic [3:0] mask,
                        input logic [2:0] cnt, input logic pass, output int e0);
      int h;
      @(negedge clk);
      if (inst == 0) tt1 = tt;
      else           tt3 = tt;
      h  = hold_of(inst);
      e0 = cyc + 1;
      sb.push_back('{inst: inst, mask: mask, cnt: cnt, pass: pass,
                     done_cyc: e0 + 4 * (h + 2), busy_cycles: 4 * (h + 2)});
      start_pulse(inst);
   endtask

   task automatic sweep(input int inst, input logic [3:0] tt, input logic [3:0] mask,
                        input logic [2:0] cnt, input logic pass);
      int e0;
      issue(inst, tt, mask, cnt, pass, e0);
      wait_cyc(e0 + 4 * (hold_of(inst) + 2) + 3);
   endtask

   initial begin
      int e0;
      rst       = 1'b1;
      if1.start = 1'b0;
      if3.start = 1'b0;
      tt1       = TT_NOR;
      tt3       = TT_NOR;
      repeat (3) @(negedge clk);
      check("rst_outs1", int'({if1.a, if1.b, if1.vec_idx, if1.busy, if1.done, if1.pass,
                               if1.err_count, if1.err_mask}), 0);
      check("rst_outs3", int'({if3.a, if3.b, if3.vec_idx, if3.busy, if3.done, if3.pass,
                               if3.err_count, if3.err_mask}), 0);
      rst = 1'b0;
      @(negedge clk);

      // good NOR, faulty OR gate, single stuck vector
      sweep(0, TT_NOR,     4'b0000, 3'd0, 1'b1);
      check("pass_held", int'(if1.pass), 1);
      sweep(0, TT_OR,      4'b1111, 3'd4, 1'b0);
      check("mask_held", int'(if1.err_mask), 15);
      sweep(0, TT_NOR_S11, 4'b1000, 3'd1, 1'b0);

      // longer settle time
      sweep(1, TT_NOR,     4'b0000, 3'd0, 1'b1);

      // start while busy and during DONE is ignored
      issue(0, TT_NOR, 4'b0000, 3'd0, 1'b1, e0);
      wait_cyc(e0 + 4);
      start_pulse(0);
      wait_cyc(e0 + 12);
      check("done_at_e12", int'(if1.done), 1);
      start_pulse(0);
      check("idle_at_e13", int'({if1.busy, if1.done}), 0);
      @(negedge clk);
      check("start_not_queued", int'(if1.busy), 0);
      wait_cyc(e0 + 18);

      // reset while vector 2 is in progress
      @(negedge clk);
      tt1 = TT_NOR;
      e0  = cyc + 1;
      start_pulse(0);
      wait_cyc(e0 + 6);
      check("mid_vec2", int'(if1.vec_idx), 2);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_outs", int'({if1.a, if1.b, if1.vec_idx, if1.busy, if1.done, if1.pass,
                                  if1.err_count, if1.err_mask}), 0);
      rst = 1'b0;
      repeat (16) @(negedge clk);
      check("post_rst_idle", int'({if1.busy, if1.done}), 0);
      sweep(0, TT_NOR, 4'b0000, 3'd0, 1'b1);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
